nios_simple_cpu_jtag_debug_host: RTL and testbench

Initiator (host) end of the Nios II virtual-JTAG debug interface, clocked from the system clock. Accepts debug commands (IR value plus DR word) over a valid/ready port. Sequences the virtual JTAG states UIR, CDR, SDR, UDR and RTI on the vji_* pins, shifting the DR out on TDI while capturing TDO. Drives the debug module directly in simulation and in on-chip self-test builds where no physical JTAG hub exists.

---
 rtl/nios_simple_cpu_jtag_debug_host_if.sv | 37 +++
 rtl/nios_simple_cpu_jtag_debug_host.sv | 140 ++++++++++++++
 tb/tb_nios_simple_cpu_jtag_debug_host.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nios_simple_cpu_jtag_debug_host_if.sv
// Command/response and virtual-JTAG pin bundle for the Nios II debug host.
// master = host side (drives vji_* and responses); slave = module/environment side.
interface nios_simple_cpu_jtag_debug_host_if #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_data;
    logic                rsp_valid;
    logic [DR_WIDTH-1:0] rsp_data;
    logic                busy;
    logic                vji_tck;
    logic                vji_tdi;
    logic                vji_tdo;
    logic [IR_WIDTH-1:0] vji_ir_in;
    logic                vji_uir;
    logic                vji_cdr;
    logic                vji_sdr;
    logic                vji_udr;
    logic                vji_rti;

    modport master (
        input  cmd_valid, cmd_ir, cmd_data, vji_tdo,
        output cmd_ready, rsp_valid, rsp_data, busy,
               vji_tck, vji_tdi, vji_ir_in,
               vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
    );

    modport slave (
        output cmd_valid, cmd_ir, cmd_data, vji_tdo,
        input  cmd_ready, rsp_valid, rsp_data, busy,
               vji_tck, vji_tdi, vji_ir_in,
               vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
    );
endinterface

// File: rtl/nios_simple_cpu_jtag_debug_host.sv
// Virtual-JTAG host: runs UIR/CDR/SDR/UDR/RTI for one IR+DR command, returns captured TDO word.
// Latency: rsp_valid 1+(DR_WIDTH+4)*2*TCK_DIV clks after accept (2*TCK_DIV less on IR cache hit).
// Backpressure: cmd_ready low from accept through DONE; optional IR cache via NIOS_SIMPLE_JTAG_HOST_IR_CACHE_EN.
module nios_simple_cpu_jtag_debug_host #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic clk,
    input  logic reset_n,
    nios_simple_cpu_jtag_debug_host_if.master bus
);
    localparam int TP_CLKS = 2 * TCK_DIV;
    localparam int CW      = $clog2(TP_CLKS + 1);
    localparam int BW      = $clog2(DR_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [BW-1:0]       bit_cnt, bit_nxt;
    logic [DR_WIDTH-1:0] data_q;
    logic [DR_WIDTH-1:0] cap_q;
    logic [1:0]          rst_sync;
    logic                rst_n;
    logic                tp_end;
    logic                accept;
    logic                cache_hit;
    logic                in_tp;

    // Assert asynchronously, release on the second clk edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

`ifdef NIOS_SIMPLE_JTAG_HOST_IR_CACHE_EN
    logic                cache_vld;
    logic [IR_WIDTH-1:0] cache_ir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_vld <= 1'b0;
            cache_ir  <= '0;
        end else if (state == S_UIR && tp_end) begin
            cache_vld <= 1'b1;
            cache_ir  <= bus.vji_ir_in;
        end
    end
    assign cache_hit = cache_vld && (bus.cmd_ir == cache_ir);
`else
    assign cache_hit = 1'b0;
`endif

    assign tp_end = (cnt == CW'(TP_CLKS - 1));
    assign accept = bus.cmd_valid && bus.cmd_ready && (state == S_IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = cache_hit ? S_CDR : S_UIR;
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: begin
                cnt_nxt = tp_end ? '0 : cnt + CW'(1);
                if (tp_end) begin
                    case (state)
                        S_UIR: state_nxt = S_CDR;
                        S_CDR: state_nxt = S_SDR;
                        S_SDR: begin
                            if (bit_cnt == BW'(DR_WIDTH - 1)) state_nxt = S_UDR;
                            else                              bit_nxt   = bit_cnt + BW'(1);
                        end
                        S_UDR: state_nxt = S_RTI;
                        S_RTI: state_nxt = S_DONE;
                        default: state_nxt = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    assign in_tp = (state_nxt != S_IDLE) && (state_nxt != S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            bit_cnt       <= '0;
            data_q        <= '0;
            cap_q         <= '0;
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.vji_tck   <= 1'b0;
            bus.vji_tdi   <= 1'b0;
            bus.vji_ir_in <= '0;
            bus.vji_uir   <= 1'b0;
            bus.vji_cdr   <= 1'b0;
            bus.vji_sdr   <= 1'b0;
            bus.vji_udr   <= 1'b0;
            bus.vji_rti   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_nxt;
            if (accept) begin
                data_q        <= bus.cmd_data;
                bus.vji_ir_in <= bus.cmd_ir;
            end
            // TDO is taken on the clk that raises TCK, before the module shifts.
            if (state == S_SDR && cnt == CW'(TCK_DIV - 1))
                cap_q <= {bus.vji_tdo, cap_q[DR_WIDTH-1:1]};
            // Outputs are registered from next-state so they line up with the state.
            bus.cmd_ready <= (state_nxt == S_IDLE);
            bus.busy      <= (state_nxt != S_IDLE);
            bus.rsp_valid <= (state_nxt == S_DONE);
            if (state_nxt == S_DONE)
                bus.rsp_data <= cap_q;
            bus.vji_tck   <= in_tp && (cnt_nxt >= CW'(TCK_DIV));
            bus.vji_tdi   <= (state_nxt == S_SDR) ? data_q[bit_nxt] : 1'b0;
            bus.vji_uir   <= (state_nxt == S_UIR);
            bus.vji_cdr   <= (state_nxt == S_CDR);
            bus.vji_sdr   <= (state_nxt == S_SDR);
            bus.vji_udr   <= (state_nxt == S_UDR);
            bus.vji_rti   <= (state_nxt == S_RTI);
        end
    end
endmodule

// File: tb/tb_nios_simple_cpu_jtag_debug_host.sv
// Bench for the virtual-JTAG debug host: loopback shift-register model on the vji pins,
// table of commands with a response scoreboard, plus busy, reset and TCK_DIV=1 sequences.
module tb_nios_simple_cpu_jtag_debug_host;
    localparam int DW       = 38;
    localparam int IW       = 2;
    localparam int LAT_FULL = 1 + (DW + 4) * 2 * 2;
    localparam int LAT_HIT  = LAT_FULL - 2 * 2;
    localparam int LAT_DIV1 = 1 + (DW + 4) * 2 * 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    nios_simple_cpu_jtag_debug_host_if #(.DR_WIDTH(DW), .IR_WIDTH(IW)) ifa ();
    nios_simple_cpu_jtag_debug_host_if #(.DR_WIDTH(DW), .IR_WIDTH(IW)) ifb ();

    nios_simple_cpu_jtag_debug_host #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa.master));
    nios_simple_cpu_jtag_debug_host #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb.master));

    // Debug-module models: DR shift register clocked on TCK rise while in SDR.
    logic [DW-1:0] model_a, pre_a, model_b, pre_b;
    logic          load_a, load_b, tck_da, tck_db;
    always @(posedge clk) begin
        tck_da <= ifa.vji_tck;
        if (load_a) model_a <= pre_a;
        else if (ifa.vji_tck && !tck_da && ifa.vji_sdr) model_a <= {ifa.vji_tdi, model_a[DW-1:1]};
    end
    always @(posedge clk) begin
        tck_db <= ifb.vji_tck;
        if (load_b) model_b <= pre_b;
        else if (ifb.vji_tck && !tck_db && ifb.vji_sdr) model_b <= {ifb.vji_tdi, model_b[DW-1:1]};
    end
    assign ifa.vji_tdo = model_a[0];
    assign ifb.vji_tdo = model_b[0];

    // Sequencing monitor on dut_a.
    int            uir_n, cdr_n, udr_n, rti_n, sdr_rise, multi_n, order_bad, tck_idle, ir_bad, rsp_n;
    logic [4:0]    last_str;
    logic          tck_pm;
    logic [IW-1:0] exp_ir;
    logic          mon_clr;
    wire  [4:0]    strb = {ifa.vji_uir, ifa.vji_cdr, ifa.vji_sdr, ifa.vji_udr, ifa.vji_rti};

    always @(negedge clk) begin
        if (mon_clr) begin
            uir_n <= 0; cdr_n <= 0; udr_n <= 0; rti_n <= 0; sdr_rise <= 0;
            multi_n <= 0; order_bad <= 0; tck_idle <= 0; ir_bad <= 0; rsp_n <= 0;
            last_str <= '0;
        end else begin
            if (ifa.vji_uir) begin
                uir_n <= uir_n + 1;
                if (ifa.vji_ir_in !== exp_ir) ir_bad <= ir_bad + 1;
            end
            if (ifa.vji_cdr) cdr_n <= cdr_n + 1;
            if (ifa.vji_udr) udr_n <= udr_n + 1;
            if (ifa.vji_rti) rti_n <= rti_n + 1;
            if (ifa.vji_sdr && ifa.vji_tck && !tck_pm) sdr_rise <= sdr_rise + 1;
            if ($countones(strb) > 1) multi_n <= multi_n + 1;
            if (strb == 5'b0 && ifa.vji_tck) tck_idle <= tck_idle + 1;
            if (strb != 5'b0 && last_str != 5'b0 && strb != last_str && strb != (last_str >> 1))
                order_bad <= order_bad + 1;
            if (strb != 5'b0) last_str <= strb;
            if (ifa.rsp_valid) rsp_n <= rsp_n + 1;
        end
        tck_pm <= ifa.vji_tck;
    end

    int n_pass = 0;
    int n_total = 0;
    logic [DW-1:0] exp_q[$];
    bit            c_vld = 1'b0;
    logic [IW-1:0] c_ir = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Expected latency from a bench-side IR cache model.
    task automatic next_lat(input logic [IW-1:0] ir, output int lat);
`ifdef NIOS_SIMPLE_JTAG_HOST_IR_CACHE_EN
        if (c_vld && ir == c_ir) begin
            lat = LAT_HIT;
            return;
        end
        c_vld = 1'b1;
        c_ir  = ir;
`endif
        lat = LAT_FULL;
    endtask

    function automatic logic [63:0] outs_a();
        return {38'h0, ifa.cmd_ready, ifa.rsp_valid, ifa.busy, ifa.vji_tck, ifa.vji_tdi,
                ifa.vji_ir_in, strb};
    endfunction

    task automatic run_cmd(input logic [IW-1:0] ir, input logic [DW-1:0] data,
                           input logic [DW-1:0] pre, output int lat,
                           output logic [DW-1:0] rsp, output bit got);
        int n;
        @(posedge clk); #1;
        mon_clr = 1'b1; exp_ir = ir; load_a = 1'b1; pre_a = pre;
        ifa.cmd_valid = 1'b1; ifa.cmd_ir = ir; ifa.cmd_data = data;
        @(negedge clk); #1 mon_clr = 1'b0;
        n = 0;
        while (!ifa.cmd_ready && n < 500) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        ifa.cmd_valid = 1'b0; load_a = 1'b0;
        lat = 0; got = 1'b0; rsp = '0;
        while (lat < 1000) begin
            @(negedge clk); lat++;
            if (ifa.rsp_valid) begin got = 1'b1; rsp = ifa.rsp_data; break; end
        end
    endtask

    task automatic do_cmd(input string nm, input logic [IW-1:0] ir, input logic [DW-1:0] data,
                          input logic [DW-1:0] pre, input logic [DW-1:0] exp_rsp);
        int el, lat;
        logic [DW-1:0] rsp, e;
        bit got;
        next_lat(ir, el);
        exp_q.push_back(exp_rsp);
        run_cmd(ir, data, pre, lat, rsp, got);
        chk({nm, " rsp_seen"}, 64'(got), 64'd1);
        e = exp_q.pop_front();
        chk({nm, " rsp_data"}, 64'(rsp), 64'(e));
        chk({nm, " latency"}, 64'(lat), 64'(el));
        chk({nm, " model_dr"}, 64'(model_a), 64'(data));
        chk({nm, " ir_in"}, 64'(ifa.vji_ir_in), 64'(ir));
        chk({nm, " uir_clks"}, 64'(uir_n), (el == LAT_HIT) ? 64'd0 : 64'd4);
        chk({nm, " cdr_clks"}, 64'(cdr_n), 64'd4);
        chk({nm, " sdr_rises"}, 64'(sdr_rise), 64'(DW));
        chk({nm, " udr_clks"}, 64'(udr_n), 64'd4);
        chk({nm, " rti_clks"}, 64'(rti_n), 64'd4);
        chk({nm, " strobe_order"}, 64'(order_bad + multi_n), 64'd0);
        chk({nm, " tck_idle"}, 64'(tck_idle), 64'd0);
        chk({nm, " ir_during_uir"}, 64'(ir_bad), 64'd0);
    endtask

    typedef struct {
        logic [IW-1:0] ir;
        logic [DW-1:0] data;
        logic [DW-1:0] pre;
        logic [DW-1:0] exp_rsp;
    } vec_t;
    vec_t tbl[5];

    initial begin
        int d, early, lat;
        bit got;
        logic [DW-1:0] rsp;

        tbl[0] = '{2'b01, 38'h3F_0000_00A5, 38'h15_5555_5555, 38'h15_5555_5555};
        tbl[1] = '{2'b10, 38'h2A_BCDE_F012, 38'h00_1234_5678, 38'h00_1234_5678};
        tbl[2] = '{2'b10, 38'h00_0000_0001, 38'h3F_FFFF_FFFF, 38'h3F_FFFF_FFFF};
        tbl[3] = '{2'b11, 38'h3F_FFFF_FFFF, 38'h00_0000_0000, 38'h00_0000_0000};
        tbl[4] = '{2'b11, 38'h20_0000_0001, 38'h25_A5A5_A5A5, 38'h25_A5A5_A5A5};

        reset_n = 1'b0; mon_clr = 1'b0; exp_ir = '0;
        load_a = 1'b0; load_b = 1'b0; pre_a = '0; pre_b = '0;
        ifa.cmd_valid = 1'b0; ifa.cmd_ir = '0; ifa.cmd_data = '0;
        ifb.cmd_valid = 1'b0; ifb.cmd_ir = '0; ifb.cmd_data = '0;

        repeat (3) @(negedge clk);
        chk("reset outs", outs_a(), 64'd0);
        chk("reset rsp_data", 64'(ifa.rsp_data), 64'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post-reset cmd_ready", 64'(ifa.cmd_ready), 64'd1);
        chk("post-reset busy", 64'(ifa.busy), 64'd0);

        for (int i = 0; i < 5; i++)
            do_cmd($sformatf("vec%0d", i), tbl[i].ir, tbl[i].data, tbl[i].pre, tbl[i].exp_rsp);

        // Busy rejection: cmd_valid held high, data drops to 0 right after first accept.
        next_lat(2'b01, lat);
        exp_q.push_back(38'h0A_5A5A_5A5A);
        @(posedge clk); #1;
        load_a = 1'b1; pre_a = 38'h0A_5A5A_5A5A;
        ifa.cmd_valid = 1'b1; ifa.cmd_ir = 2'b01; ifa.cmd_data = 38'h1;
        @(negedge clk);
        chk("busy first ready", 64'(ifa.cmd_ready), 64'd1);
        @(posedge clk); #1;
        load_a = 1'b0; ifa.cmd_data = '0;
        d = 0; early = 0;
        while (d < 1000) begin
            @(negedge clk); d++;
            if (ifa.rsp_valid) break;
            if (ifa.cmd_ready) early++;
        end
        chk("busy ready while busy", 64'(early), 64'd0);
        chk("busy first latency", 64'(d), 64'(lat));
        chk("busy first rsp", 64'(ifa.rsp_data), 64'(exp_q.pop_front()));
        chk("busy first model", 64'(model_a), 64'd1);
        chk("busy ready in done", 64'(ifa.cmd_ready), 64'd0);
        pre_a = 38'h11_2233_4455; load_a = 1'b1;
        @(negedge clk);
        chk("busy ready after done", 64'(ifa.cmd_ready), 64'd1);
        next_lat(2'b01, lat);
        exp_q.push_back(38'h11_2233_4455);
        @(posedge clk); #1;
        ifa.cmd_valid = 1'b0; load_a = 1'b0;
        d = 0;
        while (d < 1000) begin
            @(negedge clk); d++;
            if (ifa.rsp_valid) break;
        end
        chk("busy second latency", 64'(d), 64'(lat));
        chk("busy second rsp", 64'(ifa.rsp_data), 64'(exp_q.pop_front()));
        chk("busy second model", 64'(model_a), 64'd0);

        // Reset in the middle of SDR.
        @(posedge clk); #1;
        mon_clr = 1'b1; load_a = 1'b1; pre_a = 38'h2A_AAAA_AAAA;
        ifa.cmd_valid = 1'b1; ifa.cmd_ir = 2'b10; ifa.cmd_data = 38'h15_5555_5555;
        @(negedge clk); #1 mon_clr = 1'b0;
        chk("rst ready", 64'(ifa.cmd_ready), 64'd1);
        @(posedge clk); #1;
        ifa.cmd_valid = 1'b0; load_a = 1'b0;
        repeat (60) @(negedge clk);
        chk("rst in sdr", 64'(ifa.vji_sdr), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("rst mid outs", outs_a(), 64'd0);
        chk("rst mid rsp_data", 64'(ifa.rsp_data), 64'd0);
        c_vld = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst no rsp", 64'(rsp_n), 64'd0);
        chk("rst ready after", 64'(ifa.cmd_ready), 64'd1);
        do_cmd("after_rst", 2'b10, 38'h0F_0F0F_0F0F, 38'h30_3030_3030, 38'h30_3030_3030);

        // TCK_DIV = 1 loopback.
        @(posedge clk); #1;
        load_b = 1'b1; pre_b = 38'h15_5555_5555;
        ifb.cmd_valid = 1'b1; ifb.cmd_ir = 2'b01; ifb.cmd_data = 38'h3F_0000_00A5;
        d = 0;
        @(negedge clk);
        while (!ifb.cmd_ready && d < 100) begin @(negedge clk); d++; end
        @(posedge clk); #1;
        ifb.cmd_valid = 1'b0; load_b = 1'b0;
        d = 0; got = 1'b0; rsp = '0;
        while (d < 1000) begin
            @(negedge clk); d++;
            if (ifb.rsp_valid) begin got = 1'b1; rsp = ifb.rsp_data; break; end
        end
        chk("div1 rsp_seen", 64'(got), 64'd1);
        chk("div1 latency", 64'(d), 64'(LAT_DIV1));
        chk("div1 rsp", 64'(rsp), 64'h15_5555_5555);
        chk("div1 model", 64'(model_b), 64'h3F_0000_00A5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
